// File: rtl/tensor_warp_scheduler.sv
// Tensor core warp scheduler: per-warp B-buffer load tracking, one pending compute per warp,
// round-robin grant among loaded+pending warps, multi-cycle compute, beat-wise writeback.
module tensor_warp_scheduler #(
  parameter int NUM_WARPS      = 8,
  parameter int LOAD_BEATS     = 2,
  parameter int COMPUTE_CYCLES = 4,
  parameter int WB_BEATS       = 2,
  localparam int WIDW = $clog2(NUM_WARPS),
  localparam int LBW  = $clog2(LOAD_BEATS) + 1,
  localparam int CSW  = $clog2(COMPUTE_CYCLES) + 1,
  localparam int WBW  = $clog2(WB_BEATS) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WIDW-1:0]      req_wid,
  input  logic                 req_load,
  input  logic [4:0]           req_rd,
  output logic                 buf_we,
  output logic [WIDW-1:0]      buf_wid,
  output logic [LBW-1:0]       buf_beat,
  output logic [NUM_WARPS-1:0] ready_to_fire,
  output logic [WIDW-1:0]      warp_sel,
  output logic                 tg_en,
  output logic [CSW-1:0]       tg_step,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [WIDW-1:0]      wb_wid,
  output logic [4:0]           wb_rd,
  output logic [WBW-1:0]       wb_beat,
  output logic                 busy
);
  localparam int CW = (CSW > WBW) ? CSW : WBW;

  typedef enum logic [1:0] {IDLE, COMPUTE, WB} state_t;

  state_t               state_q;
  logic [LBW-1:0]       load_cnt_q [NUM_WARPS];
  logic [NUM_WARPS-1:0] loaded_q;
  logic [NUM_WARPS-1:0] pend_q;
  logic [4:0]           rd_q [NUM_WARPS];
  logic [WIDW-1:0]      act_wid_q;
  logic [WIDW-1:0]      rr_last_q;
  logic [CW-1:0]        cnt_q;

  logic                 accept;
  logic                 wb_last;
  logic                 grant_vld;
  logic [WIDW-1:0]      grant_wid;
  logic [WIDW-1:0]      cand;
  logic [NUM_WARPS-1:0] elig;
  logic [LBW-1:0]       load_cnt_d;

  // The active warp is both loaded and pending, so its own requests are blocked while it runs.
  assign req_ready  = req_load ? !loaded_q[req_wid] : !pend_q[req_wid];
  assign accept     = req_valid && req_ready;
  assign buf_we     = accept && req_load;
  assign buf_wid    = buf_we ? req_wid : '0;
  assign buf_beat   = buf_we ? load_cnt_q[req_wid] : '0;
  assign load_cnt_d = load_cnt_q[req_wid] + LBW'(1);

  assign ready_to_fire = loaded_q;
  assign warp_sel      = act_wid_q;
  assign busy          = (state_q != IDLE);
  assign tg_en         = (state_q == COMPUTE);
  assign tg_step       = tg_en ? cnt_q[CSW-1:0] : '0;
  assign wb_valid      = (state_q == WB);
  assign wb_wid        = wb_valid ? act_wid_q : '0;
  assign wb_rd         = wb_valid ? rd_q[act_wid_q] : '0;
  assign wb_beat       = wb_valid ? cnt_q[WBW-1:0] : '0;
  assign wb_last       = wb_valid && wb_ready && (cnt_q == CW'(WB_BEATS - 1));

  // Round-robin search starting just past the last granted warp; index arithmetic wraps mod NUM_WARPS.
  always_comb begin
    elig      = pend_q & loaded_q;
    grant_vld = 1'b0;
    grant_wid = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_WARPS; i++) begin
      cand = rr_last_q + WIDW'(i);
      if (!grant_vld && elig[cand]) begin
        grant_vld = 1'b1;
        grant_wid = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      loaded_q  <= '0;
      pend_q    <= '0;
      act_wid_q <= '0;
      rr_last_q <= WIDW'(NUM_WARPS - 1);
      cnt_q     <= '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        load_cnt_q[w] <= '0;
        rd_q[w]       <= '0;
      end
    end else begin
      if (buf_we) begin
        load_cnt_q[req_wid] <= load_cnt_d;
        if (load_cnt_d == LBW'(LOAD_BEATS)) loaded_q[req_wid] <= 1'b1;
      end
      if (accept && !req_load) begin
        pend_q[req_wid] <= 1'b1;
        rd_q[req_wid]   <= req_rd;
      end

      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            act_wid_q <= grant_wid;
            rr_last_q <= grant_wid;
            cnt_q     <= '0;
            state_q   <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (cnt_q == CW'(COMPUTE_CYCLES - 1)) begin
            cnt_q   <= '0;
            state_q <= WB;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WB: begin
          if (wb_last) begin
            pend_q[act_wid_q]     <= 1'b0;
            loaded_q[act_wid_q]   <= 1'b0;
            load_cnt_q[act_wid_q] <= '0;
            cnt_q                 <= '0;
            state_q               <= IDLE;
          end else if (wb_ready) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tensor_warp_scheduler.sv
// Bench for tensor_warp_scheduler: directed scenarios with literal expectations plus a
// per-cycle comparison against a queue/counter model of the scheduling rules.
module tb_tensor_warp_scheduler;
  localparam int N  = 8;
  localparam int LB = 2;
  localparam int C  = 4;
  localparam int WB = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_load, wb_ready;
  logic [2:0] req_wid;
  logic [4:0] req_rd;
  logic       req_ready, buf_we, tg_en, wb_valid, busy;
  logic [2:0] buf_wid, warp_sel, wb_wid;
  logic [1:0] buf_beat, wb_beat;
  logic [2:0] tg_step;
  logic [4:0] wb_rd;
  logic [7:0] ready_to_fire;

  int errors = 0;
  int checks = 0;
  int dut_grants[$];

  tensor_warp_scheduler dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wid(req_wid),
    .req_load(req_load), .req_rd(req_rd),
    .buf_we(buf_we), .buf_wid(buf_wid), .buf_beat(buf_beat),
    .ready_to_fire(ready_to_fire), .warp_sel(warp_sel),
    .tg_en(tg_en), .tg_step(tg_step),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wid(wb_wid),
    .wb_rd(wb_rd), .wb_beat(wb_beat), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int  m_lcnt[N];
  bit  m_ld[N];
  bit  m_pd[N];
  int  m_rd[N];
  bit  m_run, m_ok;
  int  m_t, m_beat, m_wid, m_rr;

  always @(negedge clk) begin
    int w, g;
    bit rdy, acc, found, wbv, tge;
    logic [7:0] rtf_e;
    if (tg_en === 1'b1 && tg_step === 3'd0) dut_grants.push_back(int'(warp_sel));
    if (m_ok) begin
      w   = int'(req_wid);
      rdy = req_load ? !m_ld[w] : !m_pd[w];
      acc = req_valid && rdy;
      for (int k = 0; k < N; k++) rtf_e[k] = m_ld[k];
      tge = m_run && (m_t < C);
      wbv = m_run && (m_t >= C);
      chk("req_ready", req_ready, rdy);
      chk("buf_we", buf_we, acc && req_load);
      chk("buf_wid", buf_wid, (acc && req_load) ? w : 0);
      chk("buf_beat", buf_beat, (acc && req_load) ? m_lcnt[w] : 0);
      chk("ready_to_fire", ready_to_fire, rtf_e);
      chk("busy", busy, m_run);
      chk("warp_sel", warp_sel, m_wid);
      chk("tg_en", tg_en, tge);
      chk("tg_step", tg_step, tge ? m_t : 0);
      chk("wb_valid", wb_valid, wbv);
      chk("wb_wid", wb_wid, wbv ? m_wid : 0);
      chk("wb_rd", wb_rd, wbv ? m_rd[m_wid] : 0);
      chk("wb_beat", wb_beat, wbv ? m_beat : 0);
      // advance: arbitration sees state before this cycle's accepts
      if (!m_run) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          g = (m_rr + k) % N;
          if (!found && m_ld[g] && m_pd[g]) begin
            found = 1; m_run = 1; m_t = 0; m_beat = 0; m_wid = g; m_rr = g;
          end
        end
      end else if (m_t < C) begin
        m_t++;
      end else if (wb_ready) begin
        if (m_beat == WB - 1) begin
          m_run = 0; m_pd[m_wid] = 0; m_ld[m_wid] = 0; m_lcnt[m_wid] = 0;
        end else m_beat++;
      end
      if (acc) begin
        if (req_load) begin
          m_lcnt[w]++;
          if (m_lcnt[w] == LB) m_ld[w] = 1;
        end else begin
          m_pd[w] = 1; m_rd[w] = int'(req_rd);
        end
      end
    end
    if (reset) begin
      for (int k = 0; k < N; k++) begin m_lcnt[k] = 0; m_ld[k] = 0; m_pd[k] = 0; m_rd[k] = 0; end
      m_run = 0; m_t = 0; m_beat = 0; m_wid = 0; m_rr = N - 1; m_ok = 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input int w, input logic ld, input int rd);
    logic [31:0] wv, rv;
    wv = w; rv = rd;
    req_valid = v; req_wid = wv[2:0]; req_load = ld; req_rd = rv[4:0];
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin drive(0, 0, 0, 0); tick(); end
  endtask

  task automatic arm(input int w, input int rd);
    drive(1, w, 1, 0);  chk("arm_load0_rdy", req_ready, 1); tick();
    drive(1, w, 1, 0);  chk("arm_load1_rdy", req_ready, 1); tick();
    drive(1, w, 0, rd); chk("arm_comp_rdy", req_ready, 1);  tick();
  endtask

  task automatic watch_op(input int ew, input int erd, input string tag);
    int gap, tgc, wbc;
    bit done;
    gap = 0; tgc = 0; wbc = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      drive(0, 0, 0, 0);
      if (tg_en) begin
        chk({tag, "_step"}, tg_step, tgc);
        tgc++;
      end else if (tgc == 0 && !wb_valid) gap++;
      if (wb_valid && wb_ready) begin
        chk({tag, "_wb_wid"}, wb_wid, ew);
        chk({tag, "_wb_rd"}, wb_rd, erd);
        chk({tag, "_wb_beat"}, wb_beat, wbc);
        wbc++;
        if (wbc == WB) done = 1;
      end
      tick();
    end
    chk({tag, "_gap"}, gap, 1);
    chk({tag, "_tg_cycles"}, tgc, 4);
    chk({tag, "_wb_beats"}, wbc, 2);
    chk({tag, "_rtf_after"}, ready_to_fire[ew], 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_grants[12];
    bit stall_ok;
    exp_grants = '{3, 2, 0, 1, 5, 6, 1, 5, 6, 4, 7, 3};
    reset = 1; wb_ready = 1;
    req_valid = 0; req_wid = 0; req_load = 0; req_rd = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    drive(0, 0, 0, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rtf", ready_to_fire, 0);
    chk("rst_warp_sel", warp_sel, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_tg_en", tg_en, 0);
    chk("rst_wb_valid", wb_valid, 0);

    // T1: load warp 3 twice, compute rd=7
    drive(1, 3, 1, 0); chk("t1_beat0", buf_beat, 0); tick();
    drive(1, 3, 1, 0); chk("t1_beat1", buf_beat, 1); tick();
    chk("t1_rtf", ready_to_fire, 8'h08);
    drive(1, 3, 0, 7); tick();
    watch_op(3, 7, "t1");

    // T2: compute before load does not fire; fires 2 cycles after second load
    drive(1, 2, 0, 9); tick();
    idle(5);
    chk("t2_no_fire_busy", busy, 0);
    chk("t2_no_fire_rtf", ready_to_fire, 0);
    drive(1, 2, 1, 0); tick();
    drive(1, 2, 1, 0); tick();
    watch_op(2, 9, "t2");

    // T3: warp 0 op holds the FSM while 1, 5, 6 become loaded and pending
    drive(1, 0, 1, 0); tick();
    drive(1, 0, 1, 0); tick();
    drive(1, 0, 0, 1); tick();
    wb_ready = 0;
    arm(1, 17); arm(5, 18); arm(6, 19);
    chk("t3_all_ready", ready_to_fire, 8'h63);
    wb_ready = 1;
    idle(40);

    // T4: re-arm; rr continues past 6 and wraps to 1
    arm(1, 21); arm(5, 22); arm(6, 23);
    idle(40);

    // T5: blocked load/compute on loaded/pending warp, WB stall with concurrent loads elsewhere
    drive(1, 4, 1, 0); tick();
    drive(1, 4, 1, 0); tick();
    drive(1, 4, 1, 0); chk("t5_third_load_blocked", req_ready, 0); chk("t5_third_load_no_we", buf_we, 0); tick();
    drive(1, 4, 0, 11); chk("t5_comp_rdy", req_ready, 1); tick();
    wb_ready = 0;
    drive(1, 4, 0, 12); chk("t5_second_comp_blocked", req_ready, 0); tick();
    for (int c = 0; c < 20 && !wb_valid; c++) begin
      drive(1, 4, 1, 0); chk("t5_busy_load_blocked", req_ready, 0); tick();
    end
    stall_ok = 1;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) drive(1, 7, 1, 0); else drive(1, 7, 0, 13);
      chk("t5_stall_wb_valid", wb_valid, 1);
      chk("t5_stall_wb_wid", wb_wid, 4);
      chk("t5_stall_wb_rd", wb_rd, 11);
      chk("t5_stall_wb_beat", wb_beat, 0);
      chk("t5_other_rdy", req_ready, 1);
      chk("t5_other_we", buf_we, (i < 2));
      tick();
    end
    wb_ready = 1;
    drive(0, 0, 0, 0); chk("t5_beat0", wb_beat, 0); chk("t5_hs_block", req_ready, 1); tick();
    drive(1, 4, 1, 0); chk("t5_beat1", wb_beat, 1); chk("t5_hs_cycle_rdy", req_ready, 0);
    req_valid = 0; #1; tick();
    drive(0, 4, 1, 0); chk("t5_after_rdy", req_ready, 1); chk("t5_after_rtf4", ready_to_fire[4], 0);
    tick();
    idle(20);

    // T6: reset during compute step 2 aborts the operation
    arm(3, 5);
    for (int c = 0; c < 20 && !(tg_en && tg_step == 3'd2); c++) begin drive(0, 0, 0, 0); tick(); end
    chk("t6_reach_step2", tg_step, 2);
    reset = 1;
    drive(0, 0, 0, 0); tick();
    chk("t6_busy", busy, 0);
    chk("t6_tg_en", tg_en, 0);
    chk("t6_rtf", ready_to_fire, 0);
    chk("t6_wb_valid", wb_valid, 0);
    reset = 0;
    idle(15);

    chk("grant_count", dut_grants.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < dut_grants.size()) chk("grant_order", dut_grants[i], exp_grants[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tensor_warp_scheduler.md
# tensor_warp_scheduler

Control block in front of the tensor core datapath. It tracks per-warp B-operand loading into the per-warp, per-thread-group B buffers and queues one pending compute request per warp. It arbitrates round-robin among warps that are both loaded and pending, drives the warp selector feeding the thread groups, and sequences the multi-cycle compute. It then returns results through a beat-wise writeback handshake.

## Interface
- NUM_WARPS, 8, warps tracked (power of 2, ≥2)
- LOAD_BEATS, 2, load ops needed to fill one warp's B buffer (≥1)
- COMPUTE_CYCLES, 4, thread-group compute steps per operation (≥1)
- WB_BEATS, 2, writeback beats per operation (≥1)
- WIDW = $clog2(NUM_WARPS) (derived)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request from issue
- req_ready  out  1  request accepted when req_valid & req_ready
- req_wid  in  WIDW  request warp
- req_load  in  1  1 = B-operand load, 0 = compute
- req_rd  in  5  destination register (compute only)
- buf_we  out  1  B buffer write strobe
- buf_wid  out  WIDW  B buffer warp index
- buf_beat  out  $clog2(LOAD_BEATS)+1  B buffer beat index
- ready_to_fire  out  NUM_WARPS  per-warp loaded flag
- warp_sel  out  WIDW  B buffer mux select to thread groups
- tg_en  out  1  thread groups compute this cycle
- tg_step  out  $clog2(COMPUTE_CYCLES)+1  current compute step
- wb_valid  out  1  writeback beat valid
- wb_ready  in  1  writeback sink ready
- wb_wid  out  WIDW  writeback warp
- wb_rd  out  5  writeback register
- wb_beat  out  $clog2(WB_BEATS)+1  writeback beat index
- busy  out  1  FSM not IDLE

## Operation
Per-warp state is load_cnt[w], loaded[w] (= ready_to_fire[w]), pend[w], and rd_q[w]. Global state is the FSM (IDLE, COMPUTE, WB), act_wid, step/beat counter, and rr_last.

- req_ready, combinational from registered state:
  - load: !loaded[req_wid]
  - compute: !pend[req_wid]
- Accepted load:
  - buf_we=1, buf_wid=req_wid, buf_beat=load_cnt[req_wid] in the same cycle (combinational).
  - load_cnt increments.
  - On the LOAD_BEATS-th beat, loaded[w] is set and the counter holds at LOAD_BEATS.
- Accepted compute: sets pend[w] and captures rd_q[w]=req_rd. Compute may be accepted before the warp is loaded.
- IDLE:
  - eligible = pend & loaded, using registered values.
  - If eligible is nonzero, grant the first set bit searching from rr_last+1 upward with wrap.
  - On grant: act_wid<=grant, rr_last<=grant, go to COMPUTE with step=0.
- COMPUTE:
  - tg_en=1, tg_step=step.
  - step increments each cycle. After step COMPUTE_CYCLES-1, go to WB with beat=0.
- WB:
  - wb_valid=1, wb_wid=act_wid, wb_rd=rd_q[act_wid], wb_beat=beat.
  - beat advances only on wb_valid&wb_ready.
  - On the final beat handshake: clear pend, loaded, and load_cnt for act_wid, then go to IDLE.
- warp_sel = act_wid at all times. It holds its value in IDLE.
- Outputs default to 0 when inactive: buf_we, tg_en, wb_valid, plus the associated index outputs.
- The active warp is loaded, so its loads are blocked. The active warp is pending, so its computes are blocked. Its buffer therefore cannot change mid-compute.

## Timing
- Reset values:
  - FSM=IDLE.
  - All per-warp state cleared; ready_to_fire=0.
  - act_wid=0, warp_sel=0.
  - rr_last=NUM_WARPS-1, so warp 0 has first priority.
  - All strobes 0, busy=0, req_ready=1.
  - Reset mid-operation aborts immediately; no writeback completes.
- Latency:
  - Warp already loaded, compute accepted at cycle T: pend visible T+1, grant at T+1, tg_en cycles T+2..T+1+COMPUTE_CYCLES.
  - First wb_valid at T+2+COMPUTE_CYCLES.
  - Next grant no earlier than the cycle after the final WB handshake (one IDLE cycle per operation minimum).
- A load that completes at cycle T makes its warp eligible at T+1.
- WB with wb_ready held low: wb_valid and all wb_* outputs stay stable; no counter advances.
- Clears at the WB handshake take effect the next cycle. req_ready for that warp is 0 in the handshake cycle and 1 afterward.
- Loads to other warps and compute requests to other warps are accepted in every FSM state.

## Test plan
- Reset, then load warp 3 twice, then compute warp 3 with rd=7:
  - ready_to_fire=0x08 after the second beat.
  - tg_en for 4 cycles, steps 0..3.
  - wb_valid for 2 beats with wb_wid=3, wb_rd=7.
  - ready_to_fire=0 afterward.
- Compute warp 2 with no loads: nothing fires. Then two loads to warp 2: compute starts 2 cycles after the second load.
- Warps 1, 5, 6 loaded and pending simultaneously after reset: grant order 1, 5, 6. Re-arm all three: order continues 1, 5, 6 per the rr_last wrap.
- Third load to a loaded warp: req_ready=0 until that warp's WB completes. A second compute to a pending warp is likewise stalled.
- wb_ready low 3 cycles on beat 0: wb outputs stable, beat stays 0. Concurrent loads to other warps are accepted.
- reset asserted during COMPUTE step 2: next cycle busy=0, tg_en=0, ready_to_fire=0, no wb_valid.
